// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver (scan code set 2) driving the toggle-strobed 11-bit ps2_key bus.
// Optional odd-parity rejection is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_encoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 12000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT   = '1;

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
    logic [FW-1:0] clk_fcnt_q, clk_fcnt_d, dat_fcnt_q, dat_fcnt_d;
    logic          clk_prev_q;
    logic          fall;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [10:0]   key_q, key_d;
    logic          parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q, parity_d;
    assign parity_ok = ^{shift_q, parity_q};
`else
    assign parity_ok = 1'b1;
`endif

    // A line's filtered level only moves after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        clk_fcnt_d = '0;
        dat_filt_d = dat_filt_q;
        dat_fcnt_d = '0;
        if (clk_sync_q != clk_filt_q) begin
            if (clk_fcnt_q == FCNT_MAX) clk_filt_d = ~clk_filt_q;
            else                        clk_fcnt_d = clk_fcnt_q + 1'b1;
        end
        if (dat_sync_q != dat_filt_q) begin
            if (dat_fcnt_q == FCNT_MAX) dat_filt_d = ~dat_filt_q;
            else                        dat_fcnt_d = dat_fcnt_q + 1'b1;
        end
    end

    assign fall = clk_prev_q & ~clk_filt_q;

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        to_cnt_d    = to_cnt_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
        parity_d    = parity_q;
`endif
        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                if (!dat_filt_q) bit_cnt_d = 4'd1;
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {dat_filt_q, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
`ifdef PS2_PARITY_CHECK_EN
                parity_d  = dat_filt_q;
`endif
                bit_cnt_d = 4'd10;
            end else begin
                bit_cnt_d = 4'd0;
                if (dat_filt_q && parity_ok) begin
                    rx_byte_d  = shift_q;
                    rx_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
        end else begin
            if (to_cnt_q != TO_SAT) to_cnt_d = to_cnt_q + 1'b1;
            if (bit_cnt_q != 4'd0 && to_cnt_q == TO_MAX) begin
                bit_cnt_d   = 4'd0;
                shift_d     = '0;
                frame_err_d = 1'b1;
            end
        end
    end

    // Prefix bytes only set flags; a terminating code consumes them into one event.
    always_comb begin
        key_d = key_q;
        ext_d = ext_q;
        brk_d = brk_q;
        if (rx_valid_q) begin
            case (rx_byte_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    key_d = {~key_q[10], ~brk_q, ext_q, rx_byte_q};
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            dat_meta_q  <= 1'b1;
            dat_sync_q  <= 1'b1;
            clk_filt_q  <= 1'b1;
            dat_filt_q  <= 1'b1;
            clk_fcnt_q  <= '0;
            dat_fcnt_q  <= '0;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_q       <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            dat_meta_q  <= ps2_dat_in;
            dat_sync_q  <= dat_meta_q;
            clk_filt_q  <= clk_filt_d;
            dat_filt_q  <= dat_filt_d;
            clk_fcnt_q  <= clk_fcnt_d;
            dat_fcnt_q  <= dat_fcnt_d;
            clk_prev_q  <= clk_filt_q;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            key_q       <= key_d;
`ifdef PS2_PARITY_CHECK_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign ps2_key   = key_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Self-checking bench for ps2_key_encoder: directed scenarios plus randomized frames
// checked against an event-level keyboard model.
module tb_ps2_key_encoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 12000;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_dat_in = 1'b1;
    logic [10:0] ps2_key;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int valid_seen = 0;
    int err_seen = 0;
    int exp_valid = 0;
    int exp_err = 0;

    logic [10:0] ref_key = '0;
    logic        ref_ext = 1'b0;
    logic        ref_brk = 1'b0;
    logic [7:0]  exp_rx = '0;

    ps2_key_encoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_key(ps2_key),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    always @(negedge clk_sys) begin
        if (rx_valid) valid_seen++;
        if (frame_err) err_seen++;
    end

    // Keyboard event model: prefixes set flags, special bytes clear them, anything else is a key.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) ref_ext = 1'b1;
        else if (b == 8'hF0) ref_brk = 1'b1;
        else if (b == 8'hE1 || b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE) begin
            ref_ext = 1'b0;
            ref_brk = 1'b0;
        end else begin
            ref_key = {~ref_key[10], ~ref_brk, ref_ext, b};
            ref_ext = 1'b0;
            ref_brk = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat_in = b;
        cycles(20);
        ps2_clk_in = 1'b0;
        cycles(40);
        ps2_clk_in = 1'b1;
        cycles(20);
    endtask

    task automatic frame(input logic [7:0] data, input logic par, input logic stop);
        logic ok;
        ok = stop;
`ifdef PS2_PARITY_CHECK_EN
        if (($countones({data, par}) % 2) == 0) ok = 1'b0;
`endif
        if (ok) begin
            exp_valid++;
            exp_rx = data;
            model_byte(data);
        end else begin
            exp_err++;
        end
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i]);
        ps2_bit(par);
        ps2_bit(stop);
        ps2_dat_in = 1'b1;
        cycles(30);
    endtask

    task automatic good(input logic [7:0] data);
        frame(data, ~^data, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cycles(5);
        reset = 1'b0;
        @(negedge clk_sys);
        total++;
        if (ps2_key !== 11'h000 || rx_byte !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: key=%h byte=%h valid=%b err=%b, want all zero",
                     ps2_key, rx_byte, rx_valid, frame_err);
        end
        cycles(50);
    endtask

    task automatic test_basic;
        logic [7:0] d;
        logic seen;
        d = 8'h29;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(~^d);
        ps2_dat_in = 1'b1;
        cycles(20);
        ps2_clk_in = 1'b0;
        exp_valid++;
        exp_rx = d;
        model_byte(d);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk_sys);
            seen = rx_valid;
        end
        total++;
        if (!seen || rx_byte !== 8'h29 || ps2_key !== 11'h000) begin
            bad++;
            $display("[TB] FAIL basic_rx_valid: seen=%b byte=%h key=%h, want 1/29/000", seen, rx_byte, ps2_key);
        end
        @(negedge clk_sys);
        total++;
        if (ps2_key !== 11'h629) begin
            bad++;
            $display("[TB] FAIL basic_latency: key=%h, want 629", ps2_key);
        end
        ps2_clk_in = 1'b1;
        cycles(300);
        total++;
        if (ps2_key !== 11'h629 || valid_seen !== exp_valid) begin
            bad++;
            $display("[TB] FAIL basic_idle_hold: key=%h valid=%0d, want 629/%0d", ps2_key, valid_seen, exp_valid);
        end
    endtask

    task automatic test_break;
        good(8'hF0);
        total++;
        if (ps2_key !== 11'h629) begin
            bad++;
            $display("[TB] FAIL break_prefix: key=%h, want 629", ps2_key);
        end
        good(8'h29);
        total++;
        if (ps2_key !== 11'h029) begin
            bad++;
            $display("[TB] FAIL break_event: key=%h, want 029", ps2_key);
        end
    endtask

    task automatic test_extended;
        good(8'hE0); good(8'h75);
        total++;
        if (ps2_key !== 11'h775) begin
            bad++;
            $display("[TB] FAIL ext_make: key=%h, want 775", ps2_key);
        end
        good(8'hE0); good(8'hF0); good(8'h75);
        total++;
        if (ps2_key !== 11'h175) begin
            bad++;
            $display("[TB] FAIL ext_break_e0f0: key=%h, want 175", ps2_key);
        end
        good(8'hF0); good(8'hE0); good(8'h6B);
        total++;
        if (ps2_key !== 11'h56B) begin
            bad++;
            $display("[TB] FAIL ext_break_f0e0: key=%h, want 56b", ps2_key);
        end
    endtask

    task automatic test_timeout;
        int err0;
        err0 = err_seen;
        for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        cycles(TIMEOUT + 10);
        exp_err++;
        total++;
        if (err_seen - err0 !== 1 || ps2_key !== 11'h56B) begin
            bad++;
            $display("[TB] FAIL timeout_abort: err_pulses=%0d key=%h, want 1/56b", err_seen - err0, ps2_key);
        end
        good(8'h1C);
        total++;
        if (ps2_key !== 11'h21C) begin
            bad++;
            $display("[TB] FAIL timeout_recover: key=%h, want 21c", ps2_key);
        end
    endtask

    task automatic test_bad_frame;
        frame(8'h29, 1'b0, 1'b0);
        total++;
        if (ps2_key !== 11'h21C || err_seen !== exp_err) begin
            bad++;
            $display("[TB] FAIL bad_stop: key=%h err=%0d, want 21c/%0d", ps2_key, err_seen, exp_err);
        end
        frame(8'h29, 1'b1, 1'b1);
        total++;
`ifdef PS2_PARITY_CHECK_EN
        if (ps2_key !== 11'h21C || err_seen !== exp_err) begin
            bad++;
            $display("[TB] FAIL bad_parity: key=%h err=%0d, want 21c/%0d", ps2_key, err_seen, exp_err);
        end
`else
        if (ps2_key !== 11'h629 || err_seen !== exp_err) begin
            bad++;
            $display("[TB] FAIL ignored_parity: key=%h err=%0d, want 629/%0d", ps2_key, err_seen, exp_err);
        end
`endif
    endtask

    task automatic test_glitch;
        logic [10:0] key0;
        key0 = ps2_key;
        ps2_dat_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2_clk_in = 1'b0;
            cycles(FILTER_LEN - 2);
            ps2_clk_in = 1'b1;
            cycles(40);
        end
        ps2_dat_in = 1'b1;
        cycles(40);
        good(8'hAA); good(8'hFA);
        total++;
        if (ps2_key !== key0 || err_seen !== exp_err || valid_seen !== exp_valid) begin
            bad++;
            $display("[TB] FAIL glitch_and_special: key=%h err=%0d valid=%0d, want %h/%0d/%0d",
                     ps2_key, err_seen, valid_seen, key0, exp_err, exp_valid);
        end
        good(8'hE0); good(8'hAA); good(8'h75);
        total++;
        if (ps2_key !== ref_key || ps2_key[8] !== 1'b0 || ps2_key[7:0] !== 8'h75) begin
            bad++;
            $display("[TB] FAIL special_clears_ext: key=%h, want %h", ps2_key, ref_key);
        end
    endtask

    task automatic test_reset_midframe;
        for (int i = 0; i < 6; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        ref_key = '0;
        ref_ext = 1'b0;
        ref_brk = 1'b0;
        @(negedge clk_sys);
        total++;
        if (ps2_key !== 11'h000 || rx_byte !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_midframe: key=%h byte=%h valid=%b err=%b, want zeros",
                     ps2_key, rx_byte, rx_valid, frame_err);
        end
        cycles(50);
        good(8'h29);
        total++;
        if (ps2_key !== 11'h629 || err_seen !== exp_err || rx_byte !== 8'h29) begin
            bad++;
            $display("[TB] FAIL post_reset_frame: key=%h err=%0d byte=%h, want 629/%0d/29",
                     ps2_key, err_seen, rx_byte, exp_err);
        end
    endtask

    task automatic test_random;
        logic [7:0] specials [5];
        logic [7:0] d;
        logic p, s;
        int r;
        specials[0] = 8'hE1; specials[1] = 8'hFA; specials[2] = 8'hAA;
        specials[3] = 8'hEE; specials[4] = 8'hFE;
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) d = 8'hE0;
            else if (r < 4) d = 8'hF0;
            else if (r == 4) d = specials[$urandom_range(0, 4)];
            else d = 8'($urandom_range(0, 255));
            p = ~^d;
            s = 1'b1;
            r = int'($urandom_range(0, 7));
            if (r == 0) s = 1'b0;
            else if (r == 1) p = ~p;
            frame(d, p, s);
            total++;
            if (ps2_key !== ref_key || rx_byte !== exp_rx || err_seen !== exp_err || valid_seen !== exp_valid) begin
                bad++;
                $display("[TB] FAIL random_%0d: byte_in=%h key=%h rx=%h err=%0d valid=%0d, want %h/%h/%0d/%0d",
                         n, d, ps2_key, rx_byte, err_seen, valid_seen, ref_key, exp_rx, exp_err, exp_valid);
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_break;
        test_extended;
        test_timeout;
        test_bad_frame;
        test_glitch;
        test_reset_midframe;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_encoder.md
Name: ps2_key_encoder

Overview:
- Producer side of the 11-bit `ps2_key` event bus that the core's keyboard handler consumes.
- Bus format: bit 10 toggle strobe, bit 9 pressed, bit 8 extended, bits 7:0 scan code.
- Deserialises a physical PS/2 keyboard (scan code set 2) from synchronised clock/data lines and decodes the E0/F0 prefixes.
- Emits one toggle-strobed event per key make/break, so the existing key handler is driven directly without the HPS.

Parameters:
- FILTER_LEN, 8: consecutive `clk_sys` samples a PS/2 line must hold a new level before the filtered level changes.
- TIMEOUT, 12000: `clk_sys` cycles of no falling PS/2 clock edge, mid-frame, before the partial frame is aborted.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_clk_in  in  1  raw PS/2 clock line; asynchronous; idles high.
- ps2_dat_in  in  1  raw PS/2 data line; asynchronous; idles high.
- ps2_key  out  11  {toggle, pressed, extended, code[7:0]}.
- rx_byte  out  8  last correctly received byte (debug).
- rx_valid  out  1  one-cycle pulse when `rx_byte` updates.
- frame_err  out  1  one-cycle pulse on any aborted or rejected frame.

Behaviour:
- Reset (synchronous, active-high, on `clk_sys`):
  - `ps2_key`=0, `rx_byte`=0, `rx_valid`=0, `frame_err`=0.
  - Filtered lines = 1, filter counters = 0, bit counter = 0, timeout counter = 0, ext/brk flags = 0.
  - Reset asserted mid-frame discards the partial frame; no event is emitted.
- Input conditioning:
  - Two-flop synchroniser per line.
  - Per-line filter: the counter increments while the synchronised level differs from the filtered level, and clears otherwise. Reaching FILTER_LEN-1 flips the filtered level and clears the counter.
  - A falling edge = filtered clock 1→0 (one-cycle internal strobe).
- Frame receive (on each falling edge; bit counter 0..10):
  - Bit 0 (start): must be 0. If 1, the frame is discarded silently, the counter stays 0, and there is no `frame_err`.
  - Bits 1-8: data, LSB first, shifted into the shift register.
  - Bit 9: parity (see Optional Feature).
  - Bit 10 (stop):
    - If 1 and parity is accepted: the next cycle `rx_byte`=shift register and `rx_valid`=1 for one cycle.
    - Otherwise: `frame_err`=1 for one cycle and no byte.
    - In both cases the counter returns to 0.
- Timeout:
  - The counter clears on every falling edge and increments otherwise (saturating).
  - When bit counter ≠ 0 and timeout counter = TIMEOUT-1: bit counter → 0, `frame_err` pulses, and the shift register is discarded.
- Decode, acting in the cycle after `rx_valid`:
  - E0: ext←1.
  - F0: brk←1.
  - E1, FA, AA, EE, FE: discarded; ext and brk cleared; no event.
  - Any other byte:
    - `ps2_key`←{~ps2_key[10], ~brk, ext, byte}.
    - ext and brk cleared.
  - Prefix order E0 F0 and F0 E0 are both accepted; repeated prefixes are idempotent.
- Latency: `ps2_key` updates 2 `clk_sys` cycles after the stop-bit falling edge is detected (1 to `rx_valid`, 1 to decode).
- Events never coalesce: the byte rate is far slower than the 2-cycle decode, so no buffering is needed.
- `ps2_key` holds its value between events; only bit 10 signals a new event.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a frame whose data plus parity has an even number of ones is rejected. `frame_err` pulses, no `rx_valid`, and decoder flags are unchanged.
- Undefined: the parity bit is sampled and ignored; only start, stop and timeout are checked.

Test Plan:
1. After reset, send frame 0x29 (start 0, data, odd parity 0, stop 1) → `rx_valid` pulse with `rx_byte`=0x29; 1 cycle later `ps2_key`=0x629. No further change on repeated idle.
2. From state 0x629, send F0 then 29 → no event on F0; after 29, `ps2_key`=0x029 (toggle 1→0, pressed 0).
3. Send E0 75 → `ps2_key`=0x775. Then send E0 F0 75 → `ps2_key`=0x175. Then send F0 E0 6B → `ps2_key`=0x56B.
4. Drive 5 bits of a frame then hold the clock high for TIMEOUT+10 cycles → exactly one `frame_err` pulse, `ps2_key` unchanged. Then send 0x1C → `ps2_key` code 0x1C, pressed 1, toggle flipped.
5. Send 0x29 with stop bit 0 → `frame_err` pulse, no event. With PS2_PARITY_CHECK_EN, send 0x29 with parity 1 → `frame_err`, no event. Without the macro, the same frame → event 0x29.
6. Inject 0-pulses of FILTER_LEN-2 cycles on `ps2_clk_in` while idle, and send AA/FA bytes → no bit counted, no `frame_err`, no `ps2_key` change. Assert `reset` at bit 6 of a frame → all outputs 0 and the next full frame decodes normally.
